// File: rtl/zx81_pkg.sv
// Shared types and constants for the ZX81 memory arbiter.
package zx81_pkg;

    // Arbiter FSM: one grant per IDLE, RAM samples at the end of ISSUE,
    // ack and read data are presented during ACK.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Requester index positions in the request/grant vectors.
    localparam int REQ_VID = 0;
    localparam int REQ_LDR = 1;
    localparam int REQ_CPU = 2;

    // Consecutive CPU losses tolerated before the CPU is forced to win.
    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/zx81_prio_pick.sv
// Combinational fixed-priority picker with a starvation override.
// Order is vid > ldr > cpu; when starve is set the CPU jumps ahead of
// the loader, but video still wins because display timing is real-time.
module zx81_prio_pick
    import zx81_pkg::*;
(
    input  logic [2:0] req,
    input  logic       starve,
    output logic [2:0] grant,
    output logic       valid
);

    // One-hot grant of the highest-priority pending request.
    always_comb begin
        grant = 3'b000;
        if (req[REQ_VID]) begin
            grant[REQ_VID] = 1'b1;
        end else if (starve && req[REQ_CPU]) begin
            grant[REQ_CPU] = 1'b1;
        end else if (req[REQ_LDR]) begin
            grant[REQ_LDR] = 1'b1;
        end else if (req[REQ_CPU]) begin
            grant[REQ_CPU] = 1'b1;
        end
        valid = |req;
    end

endmodule

// File: rtl/zx81_mem_arbiter.sv
// Arbitrates a single-port synchronous RAM among video fetch, .P loader
// and Z80 CPU. Each access takes three cycles (IDLE grant, ISSUE, ACK);
// the RAM control pins are registered and owned by this block.
//
// Handshake: a requester holds req (with addr/we/wdata stable) until it
// sees its one-cycle ack; rdata is valid only in the ack cycle. Requests
// are not sampled in ACK, so the requester has that cycle to drop or change
// its request. An ack still pulses if the request was dropped after grant.
module zx81_mem_arbiter
    import zx81_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT  // legal range 1..15
) (
    input  logic              clk_sys,
    input  logic              reset_n,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,

    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic              ldr_we,
    input  logic [DATA_W-1:0] ldr_wdata,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,

    output logic              vid_ack,
    output logic              ldr_ack,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_wait,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        dbg_state
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [1:0]        win_q, win_d;
    logic [2:0]        ack_q, ack_d;
    logic [3:0]        starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]        req_vec;
    logic [2:0]        grant;
    logic              grant_valid;
    logic              starve;

    assign req_vec = {cpu_req, ldr_req, vid_req};
    assign starve  = (starve_q == STARVE_LIM);

    zx81_prio_pick u_pick (
        .req    (req_vec),
        .starve (starve),
        .grant  (grant),
        .valid  (grant_valid)
    );

    // Next-state, winner latch, RAM control and starvation counter.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        ack_d       = 3'b000;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    mem_en_d = 1'b1;
                    state_d  = ISSUE;
                    if (grant[REQ_VID]) begin
                        win_d       = 2'(REQ_VID);
                        mem_we_d    = 1'b0;
                        mem_addr_d  = vid_addr;
                        mem_wdata_d = '0;
                    end else if (grant[REQ_LDR]) begin
                        win_d       = 2'(REQ_LDR);
                        mem_we_d    = ldr_we;
                        mem_addr_d  = ldr_addr;
                        mem_wdata_d = ldr_wdata;
                    end else begin
                        win_d       = 2'(REQ_CPU);
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
                end
                // Loss counting happens in the same cycle as the grant.
                if (cpu_req) begin
                    if (grant[REQ_CPU]) begin
                        starve_d = 4'd0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            ISSUE: begin
                ack_d[REQ_VID] = (win_q == 2'(REQ_VID));
                ack_d[REQ_LDR] = (win_q == 2'(REQ_LDR));
                ack_d[REQ_CPU] = (win_q == 2'(REQ_CPU));
                state_d        = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            win_q       <= 2'd0;
            ack_q       <= 3'b000;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            ack_q       <= ack_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign vid_ack   = ack_q[REQ_VID];
    assign ldr_ack   = ack_q[REQ_LDR];
    assign cpu_ack   = ack_q[REQ_CPU];
    assign rdata     = mem_rdata;
    assign cpu_wait  = cpu_req & ~cpu_ack;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_zx81_mem_arbiter.sv
// Directed bench for zx81_mem_arbiter with a behavioural synchronous RAM.
// Inputs change and outputs are sampled on the falling edge.
module tb_zx81_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        vid_req, ldr_req, cpu_req;
    logic [15:0] vid_addr, ldr_addr, cpu_addr;
    logic        ldr_we, cpu_we;
    logic [7:0]  ldr_wdata, cpu_wdata;
    logic        vid_ack, ldr_ack, cpu_ack;
    logic [7:0]  rdata;
    logic        cpu_wait;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;

    logic [7:0] ram [0:65535];

    zx81_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(4)) dut (
        .clk_sys   (clk),
        .reset_n   (reset_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .ldr_req   (ldr_req),
        .ldr_addr  (ldr_addr),
        .ldr_we    (ldr_we),
        .ldr_wdata (ldr_wdata),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .vid_ack   (vid_ack),
        .ldr_ack   (ldr_ack),
        .cpu_ack   (cpu_ack),
        .rdata     (rdata),
        .cpu_wait  (cpu_wait),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Behavioural single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Count write strobes seen by the RAM.
    always @(posedge clk) begin
        if (mem_en && mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int waits, we_base, vid_at, ldr_at, cpu_at, ldr_n, acks;
    logic [7:0] vid_rd, cpu_rd;

    initial begin
        reset_n = 1'b0;
        vid_req = 1'b1; ldr_req = 1'b1; cpu_req = 1'b1;
        vid_addr = 16'h1234; ldr_addr = 16'h2000; cpu_addr = 16'h3000;
        ldr_we = 1'b0; cpu_we = 1'b0; ldr_wdata = 8'h00; cpu_wdata = 8'h00;

        // Reset values with every request asserted.
        repeat (3) tick();
        check_eq("rst_vid_ack", vid_ack, 0);
        check_eq("rst_ldr_ack", ldr_ack, 0);
        check_eq("rst_cpu_ack", cpu_ack, 0);
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_state", dbg_state, 0);

        // First IDLE after release: video wins, ack two cycles later.
        reset_n = 1'b1;
        tick();
        check_eq("rel_mem_en", mem_en, 1);
        check_eq("rel_mem_addr", mem_addr, 16'h1234);
        check_eq("rel_vid_ack_early", vid_ack, 0);
        tick();
        check_eq("rel_vid_ack", vid_ack, 1);
        check_eq("rel_ldr_ack", ldr_ack, 0);
        check_eq("rel_cpu_ack", cpu_ack, 0);
        vid_req = 1'b0; ldr_req = 1'b0; cpu_req = 1'b0;
        tick();

        // CPU write 0xA5 to 0x4000.
        cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'hA5; cpu_req = 1'b1;
        waits = 0; we_base = we_cnt;
        #1 waits += int'(cpu_wait);
        tick();
        check_eq("wr_mem_en", mem_en, 1);
        check_eq("wr_mem_we", mem_we, 1);
        check_eq("wr_mem_addr", mem_addr, 16'h4000);
        check_eq("wr_mem_wdata", mem_wdata, 8'hA5);
        check_eq("wr_ack_early", cpu_ack, 0);
        waits += int'(cpu_wait);
        tick();
        check_eq("wr_cpu_ack", cpu_ack, 1);
        check_eq("wr_mem_we_off", mem_we, 0);
        waits += int'(cpu_wait);
        cpu_req = 1'b0;
        tick();
        check_eq("wr_wait_cycles", waits, 2);
        check_eq("wr_we_pulses", we_cnt - we_base, 1);

        // CPU read of 0x4000 returns 0xA5 in the ack cycle.
        cpu_we = 1'b0; cpu_req = 1'b1; waits = 0;
        #1 waits += int'(cpu_wait);
        tick();
        check_eq("rd_mem_we", mem_we, 0);
        waits += int'(cpu_wait);
        tick();
        check_eq("rd_cpu_ack", cpu_ack, 1);
        check_eq("rd_rdata", rdata, 8'hA5);
        waits += int'(cpu_wait);
        cpu_req = 1'b0;
        check_eq("rd_wait_cycles", waits, 2);
        tick();

        // Three-way contention: vid, then ldr, then cpu.
        vid_req = 1'b1; vid_addr = 16'h4000;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h5000; ldr_wdata = 8'h3C;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5000;
        vid_at = -1; ldr_at = -1; cpu_at = -1; vid_rd = 8'h00; cpu_rd = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (vid_ack) begin vid_at = c; vid_rd = rdata; vid_req = 1'b0; end
            if (ldr_ack) begin ldr_at = c; ldr_req = 1'b0; end
            if (cpu_ack) begin cpu_at = c; cpu_rd = rdata; cpu_req = 1'b0; end
        end
        check_eq("c3_vid_at", vid_at, 2);
        check_eq("c3_ldr_at", ldr_at, 5);
        check_eq("c3_cpu_at", cpu_at, 8);
        check_eq("c3_vid_rdata", vid_rd, 8'hA5);
        check_eq("c3_cpu_rdata", cpu_rd, 8'h3C);

        // Starvation guard: CPU wins the fifth arbitration against the loader.
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h6000; ldr_wdata = 8'h11;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
        ldr_n = 0; cpu_at = -1;
        for (int c = 1; c <= 30 && cpu_at < 0; c++) begin
            tick();
            if (ldr_ack) ldr_n++;
            if (cpu_ack) begin cpu_at = c; cpu_req = 1'b0; ldr_req = 1'b0; end
        end
        check_eq("sv_ldr_wins", ldr_n, 4);
        check_eq("sv_cpu_at", cpu_at, 14);
        tick();

        // Starvation guard with video arriving at the forced arbitration.
        ldr_req = 1'b1; cpu_req = 1'b1; vid_addr = 16'h4000;
        ldr_n = 0; vid_at = -1; cpu_at = -1;
        for (int c = 1; c <= 30 && cpu_at < 0; c++) begin
            tick();
            if (ldr_ack) begin
                ldr_n++;
                if (ldr_n == 4) vid_req = 1'b1;
            end
            if (vid_ack) begin vid_at = c; vid_req = 1'b0; end
            if (cpu_ack) begin cpu_at = c; cpu_req = 1'b0; ldr_req = 1'b0; end
        end
        check_eq("sv2_ldr_wins", ldr_n, 4);
        check_eq("sv2_vid_at", vid_at, 14);
        check_eq("sv2_cpu_at", cpu_at, 17);
        tick();

        // Loader drops its request in ISSUE; access and ack still complete.
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h5100; ldr_wdata = 8'h77;
        tick();
        ldr_req = 1'b0;
        check_eq("drop_mem_we", mem_we, 1);
        tick();
        check_eq("drop_ldr_ack", ldr_ack, 1);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5100;
        tick();
        tick();
        check_eq("drop_rb_ack", cpu_ack, 1);
        check_eq("drop_rb_rdata", rdata, 8'h77);
        cpu_req = 1'b0;
        tick();

        // Reset asserted during ISSUE aborts the access with no ack.
        cpu_req = 1'b1; cpu_addr = 16'h4000;
        tick();
        check_eq("abort_mem_en_pre", mem_en, 1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_mem_en", mem_en, 0);
        check_eq("abort_state", dbg_state, 0);
        cpu_req = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 1) reset_n = 1'b1;
            acks += int'(vid_ack) + int'(ldr_ack) + int'(cpu_ack);
        end
        check_eq("abort_no_ack", acks, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zx81_mem_arbiter.md
# zx81_mem_arbiter

Arbitrates one single-port synchronous block RAM among three requesters in the ZX81 core, all on `clk_sys`. The requesters are:
- the video fetch unit, which reads display-file and character bytes;
- the `.P` file loader, which writes program images;
- the Z80 CPU, which reads and writes.

The video fetch unit has fixed highest priority, because display timing is real-time. A starvation guard ensures the CPU can never be locked out by loader traffic. The block sits between the requesters and the RAM macro; it owns all RAM control pins.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 8, RAM data width
- STARVE_MAX, 4, consecutive lost arbitrations after which the CPU is forced to win; legal range 1..15

Ports:
- clk_sys  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  reset, asynchronous and active-low
- vid_req / ldr_req / cpu_req  in  1 each  request level; held until the matching ack
- vid_addr / ldr_addr / cpu_addr  in  ADDR_W each  request address
- ldr_we / cpu_we  in  1 each  1 = write; the video port is read-only
- ldr_wdata / cpu_wdata  in  DATA_W each  write data
- vid_ack / ldr_ack / cpu_ack  out  1 each  one-cycle completion pulse
- rdata  out  DATA_W  read data; valid only in the cycle an ack is high; driven combinationally from mem_rdata
- cpu_wait  out  1  Z80 WAIT request; equals cpu_req & ~cpu_ack
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after the edge that samples mem_en

## Operation
State machine states: IDLE, ISSUE, ACK.
- **IDLE.** If any request is pending, select a winner and latch its index.
  - Drive mem_addr, mem_we and mem_wdata from the winner; set mem_en = 1.
  - Go to ISSUE.
  - With no request pending, stay in IDLE with mem_en = 0.
- **ISSUE.** The RAM samples the access on the edge that ends this cycle.
  - Clear mem_en and mem_we.
  - Set the winner's ack register.
  - Go to ACK.
- **ACK.** The winner's ack is high and rdata = mem_rdata.
  - Clear the ack.
  - Go to IDLE.
  - Requests are not sampled in ACK. This gives a requester one cycle to drop or change its request.
- **Priority order**, normally: vid > ldr > cpu.
  - Override: when starve_cnt == STARVE_MAX and cpu_req = 1, the CPU wins over the loader. The video port still beats the CPU.
- **starve_cnt**, a 4-bit register:
  - increments in IDLE when cpu_req = 1 and the CPU loses;
  - saturates at STARVE_MAX;
  - clears when the CPU wins.
- **Request dropped after grant** (before its ack): the access still completes and the ack still pulses. The requester ignores it.
- **Write data:** mem_wdata is don't-care on reads, but is driven from the winner's wdata regardless, so no extra mux select is needed.
- **Write completion:** a write's ack means the write is committed. rdata in that cycle is don't-care.

## Timing
- **Reset:**
  - state = IDLE;
  - all acks = 0;
  - mem_en = 0 and mem_we = 0;
  - mem_addr = 0 and mem_wdata = 0;
  - starve_cnt = 0.
- **Reset asserted mid-access:** the access is aborted immediately; no ack is ever issued for it.
- **Latency:** if a request is high in IDLE cycle t, its ack is high in cycle t+2, together with valid rdata.
- **Throughput:** one access per 3 cycles. The earliest next grant is made in IDLE at t+3.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Losers keep waiting, and the CPU loss counter updates in the same cycle.
- **mem_we:** high for exactly one cycle per write, coincident with mem_en.
- **cpu_wait:** combinational. It falls in the ack cycle, so the Z80 samples rdata there.

## Structure
- Package `zx81_pkg` holds:
  - `arb_state_t` enum (IDLE/ISSUE/ACK);
  - requester index constants REQ_VID = 0, REQ_LDR = 1, REQ_CPU = 2;
  - the default STARVE_MAX value.
- Sub-module `zx81_prio_pick` is purely combinational:
  - inputs: the 3-bit request vector and the starve flag;
  - outputs: the one-hot grant and a valid flag;
  - it is reused by future I/O arbitration.
- All remaining logic (FSM, latched winner index, ack registers, counter, registered memory outputs) lives in the top module.

## Test plan
- **Reset values:** hold reset_n = 0 with all requests high → all outputs 0. After release, vid_ack is high at cycle 2 of the first IDLE.
- **CPU write then read:** CPU writes 0xA5 to 0x4000 → mem_we pulses once with mem_addr = 0x4000, and cpu_ack pulses at t+2. A CPU read of 0x4000 then returns rdata = 0xA5 in the ack cycle. cpu_wait is high for exactly 2 cycles.
- **Three-way contention:** vid, ldr and cpu all request at t → grants are vid (ack t+2), then ldr (ack t+5), then cpu (ack t+8).
- **Starvation guard:** ldr_req held continuously with cpu_req = 1 and STARVE_MAX = 4 → the CPU wins the 5th arbitration. With vid_req also high at that point, vid still wins first, then the CPU.
- **Dropped request and reset abort:**
  - drop ldr_req in the ISSUE cycle → ldr_ack still pulses at t+2;
  - assert reset_n = 0 during ISSUE → no ack, mem_en = 0 immediately.
